alu_cmd_sequencer: RTL and testbench

Frame-level controller between the UART receiver and the shared ALU/comparator datapath. It collects command bytes from the RX deserializer, latches operands, and issues one ALU operation with a single-cycle enable. It then waits for the datapath's registered valid flag and streams the result to the UART transmitter as two bytes, low byte first. If the datapath returns no valid flag within a bounded window, it sends an error byte instead.

---
 rtl/alu_cmd_sequencer_pkg.sv | 34 +++
 rtl/alu_cmd_sequencer_tx_byte_mux.sv | 27 ++
 rtl/alu_cmd_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg
// Shared constants and types for the UART-to-ALU command sequencer:
//   - default operand / function-code widths
//   - command bytes (full frame, reuse frame) and the error reply byte
//   - FSM state encoding and transmit byte selector
package alu_cmd_sequencer_pkg;

  localparam int unsigned OPERAND_WIDTH_DEF = 8;
  localparam int unsigned FUN_WIDTH_DEF     = 4;

  localparam logic [7:0] CMD_FULL  = 8'hCC;
  localparam logic [7:0] CMD_REUSE = 8'hDD;
  localparam logic [7:0] ERR_BYTE  = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_GET_A    = 4'd1,
    ST_GET_B    = 4'd2,
    ST_GET_FUN  = 4'd3,
    ST_ISSUE    = 4'd4,
    ST_WAIT     = 4'd5,
    ST_SEND_LO  = 4'd6,
    ST_SEND_HI  = 4'd7,
    ST_SEND_ERR = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    TX_SEL_NONE = 2'd0,
    TX_SEL_LO   = 2'd1,
    TX_SEL_HI   = 2'd2,
    TX_SEL_ERR  = 2'd3
  } tx_sel_e;

endpackage

// File: rtl/alu_cmd_sequencer_tx_byte_mux.sv
// tx_byte_mux
// Selects the byte presented to the UART transmitter.
// Ports:
//   result_i  captured ALU result (2*OPERAND_WIDTH bits)
//   sel_i     which byte to present (none -> 0, low, high, error byte)
//   byte_o    byte to transmit
module tx_byte_mux
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH = OPERAND_WIDTH_DEF
) (
  input  logic [2*OPERAND_WIDTH-1:0] result_i,
  input  tx_sel_e                    sel_i,
  output logic [7:0]                 byte_o
);

  always_comb begin
    byte_o = '0;
    case (sel_i)
      TX_SEL_LO:  byte_o = 8'(result_i[OPERAND_WIDTH-1:0]);
      TX_SEL_HI:  byte_o = 8'(result_i[2*OPERAND_WIDTH-1:OPERAND_WIDTH]);
      TX_SEL_ERR: byte_o = ERR_BYTE;
      default:    byte_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Collects a command frame from the UART receiver, issues one ALU operation
// with a single-cycle enable, waits (bounded) for the registered result and
// streams it to the UART transmitter low byte first, or an error byte on
// timeout.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   RX_P_DATA, RX_D_VLD      received byte and its one-cycle strobe
//   ALU_A, ALU_B, ALU_FUN    latched operands and function code
//   ALU_EN                   one-cycle issue pulse
//   ALU_OUT, ALU_OUT_VLD     datapath result and its valid flag
//   TX_P_DATA, TX_D_VLD      byte to transmit and its valid (held until ready)
//   TX_READY                 transmitter accepts a byte
//   BUSY                     not idle
//   DROP                     sticky: a byte arrived while busy
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH = OPERAND_WIDTH_DEF,
  parameter int unsigned FUN_WIDTH     = FUN_WIDTH_DEF,
  parameter int unsigned TIMEOUT       = 7
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [7:0]                 RX_P_DATA,
  input  logic                       RX_D_VLD,
  output logic [OPERAND_WIDTH-1:0]   ALU_A,
  output logic [OPERAND_WIDTH-1:0]   ALU_B,
  output logic [FUN_WIDTH-1:0]       ALU_FUN,
  output logic                       ALU_EN,
  input  logic [2*OPERAND_WIDTH-1:0] ALU_OUT,
  input  logic                       ALU_OUT_VLD,
  output logic [7:0]                 TX_P_DATA,
  output logic                       TX_D_VLD,
  input  logic                       TX_READY,
  output logic                       BUSY,
  output logic                       DROP
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e                     state_q, state_d;
  logic [OPERAND_WIDTH-1:0]   a_q, a_d;
  logic [OPERAND_WIDTH-1:0]   b_q, b_d;
  logic [FUN_WIDTH-1:0]       fun_q, fun_d;
  logic [2*OPERAND_WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       drop_q, drop_d;
  logic                       sending;
  tx_sel_e                    tx_sel;

  assign sending = (state_q == ST_SEND_LO) || (state_q == ST_SEND_HI) ||
                   (state_q == ST_SEND_ERR);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;

    // Any byte outside IDLE and the GET states is lost; this includes the
    // final transmit handshake cycle, since the FSM is still in a SEND state.
    if (RX_D_VLD && (state_q == ST_ISSUE || state_q == ST_WAIT || sending)) begin
      drop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_FULL) begin
            state_d = ST_GET_A;
          end else if (RX_P_DATA == CMD_REUSE) begin
            state_d = ST_GET_FUN;
          end
        end
      end
      ST_GET_A: begin
        if (RX_D_VLD) begin
          a_d     = OPERAND_WIDTH'(RX_P_DATA);
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (RX_D_VLD) begin
          b_d     = OPERAND_WIDTH'(RX_P_DATA);
          state_d = ST_GET_FUN;
        end
      end
      ST_GET_FUN: begin
        if (RX_D_VLD) begin
          fun_d   = RX_P_DATA[FUN_WIDTH-1:0];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Valid flag takes priority over a coincident timeout.
        if (ALU_OUT_VLD) begin
          res_d   = ALU_OUT;
          state_d = ST_SEND_LO;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ST_SEND_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND_LO: begin
        if (TX_READY) state_d = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        if (TX_READY) state_d = ST_IDLE;
      end
      ST_SEND_ERR: begin
        if (TX_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    tx_sel = TX_SEL_NONE;
    case (state_q)
      ST_SEND_LO:  tx_sel = TX_SEL_LO;
      ST_SEND_HI:  tx_sel = TX_SEL_HI;
      ST_SEND_ERR: tx_sel = TX_SEL_ERR;
      default:     tx_sel = TX_SEL_NONE;
    endcase
  end

  tx_byte_mux #(
    .OPERAND_WIDTH(OPERAND_WIDTH)
  ) u_tx_mux (
    .result_i(res_q),
    .sel_i   (tx_sel),
    .byte_o  (TX_P_DATA)
  );

  // Strobes are gated by RST so a reset kills them in the same cycle.
  assign ALU_EN   = (state_q == ST_ISSUE) && !RST;
  assign TX_D_VLD = sending && !RST;
  assign BUSY     = (state_q != ST_IDLE);
  assign DROP     = drop_q;
  assign ALU_A    = a_q;
  assign ALU_B    = b_q;
  assign ALU_FUN  = fun_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  localparam int unsigned TIMEOUT = 7;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_READY;
  logic        BUSY;
  logic        DROP;

  alu_cmd_sequencer #(
    .OPERAND_WIDTH(8),
    .FUN_WIDTH    (4),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_FUN    (ALU_FUN),
    .ALU_EN     (ALU_EN),
    .ALU_OUT    (ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .TX_READY   (TX_READY),
    .BUSY       (BUSY),
    .DROP       (DROP)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: the operands the device should hold and the sticky drop.
  logic [7:0] ma, mb;
  bit         mdrop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  // One complete frame. lat = WAIT cycle in which the datapath raises its
  // valid flag (0 or > TIMEOUT means it never does).
  task automatic do_frame(input bit full, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] f, input int lat, input logic [15:0] res,
                          input int stall_lo, input bit drop_in_wait,
                          input bit drop_at_end, input bit rst_in_hi);
    logic [7:0] exp_bytes[$];
    bit         timed_out;
    timed_out = (lat == 0) || (lat > int'(TIMEOUT));
    if (timed_out) exp_bytes.push_back(8'hEE);
    else begin
      exp_bytes.push_back(res[7:0]);
      exp_bytes.push_back(res[15:8]);
    end

    if (full) begin
      send_byte(8'hCC);
      send_byte(a);
      send_byte(b);
      ma = a;
      mb = b;
    end else begin
      send_byte(8'hDD);
    end
    send_byte(f);

    // Issue cycle
    chk("issue_en", ALU_EN, 1);
    chk("issue_a", ALU_A, ma);
    chk("issue_b", ALU_B, mb);
    chk("issue_fun", ALU_FUN, f & 8'h0F);
    chk("issue_busy", BUSY, 1);
    @(negedge CLK);

    // Wait window: the device must not transmit until the flag or timeout.
    for (int w = 1; w <= int'(TIMEOUT); w++) begin
      chk("wait_en", ALU_EN, 0);
      chk("wait_txv", TX_D_VLD, 0);
      chk("wait_a", ALU_A, ma);
      ALU_OUT_VLD = (w == lat);
      ALU_OUT     = (w == lat) ? res : 16'($urandom);
      if (drop_in_wait && w == 1) begin
        RX_P_DATA = 8'h55;
        RX_D_VLD  = 1'b1;
        mdrop     = 1'b1;
      end
      @(negedge CLK);
      ALU_OUT_VLD = 1'b0;
      ALU_OUT     = 16'($urandom);
      RX_D_VLD    = 1'b0;
      if (w == lat) break;
    end

    // Transmit
    for (int i = 0; i < exp_bytes.size(); i++) begin
      chk("send_drop", DROP, mdrop);
      if (i == 0) begin
        repeat (stall_lo) begin
          TX_READY = 1'b0;
          chk("stall_txv", TX_D_VLD, 1);
          chk("stall_data", TX_P_DATA, exp_bytes[i]);
          @(negedge CLK);
        end
      end
      if (rst_in_hi && i == 1) begin
        RST      = 1'b1;
        TX_READY = 1'b1;
        #1;
        chk("rst_en_now", ALU_EN, 0);
        chk("rst_txv_now", TX_D_VLD, 0);
        @(negedge CLK);
        RST = 1'b0;
        ma = '0;
        mb = '0;
        mdrop = 1'b0;
        chk("rst_busy", BUSY, 0);
        chk("rst_txv", TX_D_VLD, 0);
        chk("rst_data", TX_P_DATA, 0);
        chk("rst_en", ALU_EN, 0);
        chk("rst_a", ALU_A, 0);
        chk("rst_b", ALU_B, 0);
        chk("rst_fun", ALU_FUN, 0);
        chk("rst_drop", DROP, 0);
        return;
      end
      TX_READY = 1'b1;
      if (drop_at_end && i == exp_bytes.size() - 1) begin
        RX_P_DATA = ($urandom_range(0, 1) == 1) ? 8'hCC : 8'($urandom);
        RX_D_VLD  = 1'b1;
        mdrop     = 1'b1;
      end
      chk("send_txv", TX_D_VLD, 1);
      chk("send_data", TX_P_DATA, exp_bytes[i]);
      @(negedge CLK);
      RX_D_VLD = 1'b0;
    end

    chk("end_busy", BUSY, 0);
    chk("end_txv", TX_D_VLD, 0);
    chk("end_drop", DROP, mdrop);
  endtask

  initial begin
    RST         = 1'b1;
    RX_P_DATA   = '0;
    RX_D_VLD    = 1'b0;
    ALU_OUT     = '0;
    ALU_OUT_VLD = 1'b0;
    TX_READY    = 1'b1;
    ma          = '0;
    mb          = '0;
    mdrop       = 1'b0;

    repeat (2) @(negedge CLK);
    chk("reset_en", ALU_EN, 0);
    chk("reset_txv", TX_D_VLD, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_drop", DROP, 0);
    chk("reset_a", ALU_A, 0);
    chk("reset_b", ALU_B, 0);
    chk("reset_fun", ALU_FUN, 0);
    chk("reset_data", TX_P_DATA, 0);
    RST = 1'b0;

    // Non-command byte in IDLE is ignored and not counted as a drop.
    send_byte(8'h42);
    chk("ignore_busy", BUSY, 0);
    chk("ignore_drop", DROP, 0);

    // Full frame, compare greater-than.
    do_frame(1, 8'h05, 8'h03, 8'h0D, 1, 16'h0002, 0, 0, 0, 0);
    // Reuse frame, less-than: operands retained.
    do_frame(0, 8'h00, 8'h00, 8'h0E, 1, 16'h0000, 0, 0, 0, 0);
    // Comparator NOP: no valid flag, error byte after TIMEOUT wait cycles.
    do_frame(1, 8'h01, 8'h01, 8'h0C, 0, 16'h0000, 0, 0, 0, 0);
    // Valid exactly at the timeout cycle wins.
    do_frame(1, 8'($urandom), 8'($urandom), 8'h3D, int'(TIMEOUT), 16'hA5C3, 0, 0, 0, 0);
    // Backpressure of 10 cycles on the low byte; FUN upper bits ignored.
    do_frame(1, 8'($urandom), 8'($urandom), 8'hF6, 2, 16'($urandom), 10, 0, 0, 0);
    // Byte during WAIT sets DROP; reset in SEND_HI clears everything.
    do_frame(1, 8'h12, 8'h34, 8'h05, 3, 16'hBEEF, 0, 1, 0, 1);
    // Byte on the final handshake edge is dropped, not a new frame.
    do_frame(0, 8'h00, 8'h00, 8'h07, 2, 16'h1357, 0, 0, 1, 0);
    chk("post_drop_idle", BUSY, 0);

    for (int n = 0; n < 24; n++) begin
      bit         full;
      int         lat;
      full = (n == 0) || ($urandom_range(0, 2) != 0);
      lat  = int'($urandom_range(0, TIMEOUT + 1));
      do_frame(full, 8'($urandom), 8'($urandom), 8'($urandom), lat, 16'($urandom),
               int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
               $urandom_range(0, 4) == 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
